// File: rtl/reset_manager_pkg.sv
// Shared types and constants for the board reset conditioner.
package reset_manager_pkg;

  // Bit 0 of the encoding is the SoC reset level; see reset_manager.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    HOLD     = 2'b01,
    BTN_WAIT = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

endpackage

// File: rtl/reset_manager_button_debouncer.sv
// Button synchronizer, polarity normalization and debounce filter.
// Output is the debounced "pressed" level (1 = pressed).
module button_debouncer
  import reset_manager_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn,
  output logic pressed
);

  localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic BTN_IDLE = BTN_ACTIVE_LOW;

  logic             sync_p0;
  logic             sync_p1;
  logic             synced_pressed;
  logic [CNT_W-1:0] cnt;

  // Synchronizer stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= BTN_IDLE;
      sync_p1 <= BTN_IDLE;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  assign synced_pressed = sync_p1 ^ BTN_ACTIVE_LOW;

  // Counter only runs while the synced level disagrees with the debounced one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (en) begin
      if (synced_pressed == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        pressed <= synced_pressed;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reset_manager.sv
// Board reset conditioner: external reset, debounced button and optional
// watchdog (RESET_MANAGER_WATCHDOG_EN) combined into one SoC reset.
module reset_manager
  import reset_manager_pkg::*;
#(
  parameter int CYCLES          = 20,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int WDT_CYCLES      = 27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       wdt_kick,
  output logic       reset_o,
  output logic [1:0] reset_cause
);

  localparam int HOLD_W = $clog2(CYCLES) + 1;

  logic              rst_sync_p0;
  logic              rst_sync_p1;
  logic              en;
  logic              btn_pressed;
  logic              wdt_timeout;
  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic [1:0]        cause_next;

  // Reset release synchronizer stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  assign en = rst_sync_p1;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_button_debouncer (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .btn    (btn),
    .pressed(btn_pressed)
  );

`ifdef RESET_MANAGER_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES) + 1;

  logic [WDT_W-1:0] wdt_cnt;
  logic [WDT_W-1:0] wdt_cnt_next;

  // A kick in the terminal cycle suppresses the timeout
  always_comb begin
    wdt_timeout  = (state == RUN) && !wdt_kick &&
                   (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
    wdt_cnt_next = wdt_cnt + WDT_W'(1);
    if (state != RUN || state_next != RUN || wdt_kick) begin
      wdt_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_cnt <= '0;
    end else if (en) begin
      wdt_cnt <= wdt_cnt_next;
    end
  end
`else
  logic unused_wdt_kick;

  assign unused_wdt_kick = wdt_kick;
  assign wdt_timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      reset_cause <= CAUSE_POR;
    end else if (en) begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      reset_cause <= cause_next;
    end
  end

  // Button has priority over a coincident watchdog timeout
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    cause_next    = reset_cause;
    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_W'(CYCLES - 1)) begin
          state_next    = RUN;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end
      RUN: begin
        if (btn_pressed) begin
          state_next = BTN_WAIT;
          cause_next = CAUSE_BTN;
        end else if (wdt_timeout) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
          cause_next    = CAUSE_WDT;
        end
      end
      BTN_WAIT: begin
        if (!btn_pressed) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = HOLD;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Encoding puts the reset level on a single flop bit, so the output is glitch-free
  always_comb begin
    reset_o = state[0];
  end

endmodule

// File: tb/tb_reset_manager.sv
// Scoreboard bench for reset_manager: stimulus queues expected reset_o/cause
// per cycle, a negedge monitor pops and compares.
module tb_reset_manager;
  import reset_manager_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b1;
  logic       wdt_kick = 1'b0;
  logic       reset_o;
  logic [1:0] reset_cause;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int           cyc;
    logic         rst;
    logic [1:0]   cause;
    logic [127:0] name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_manager #(
    .CYCLES         (4),
    .DEBOUNCE_CYCLES(8),
    .BTN_ACTIVE_LOW (1'b1),
    .WDT_CYCLES     (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .wdt_kick   (wdt_kick),
    .reset_o    (reset_o),
    .reset_cause(reset_cause)
  );

  task automatic expect_at(input int c, input logic r, input logic [1:0] ca,
                           input logic [127:0] nm);
    exp_t e;
    e.cyc   = c;
    e.rst   = r;
    e.cause = ca;
    e.name  = nm;
    q.push_back(e);
  endtask

  task automatic expect_range(input int c0, input int c1, input logic r,
                              input logic [1:0] ca, input logic [127:0] nm);
    for (int c = c0; c <= c1; c++) expect_at(c, r, ca, nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %0s: expectation for cycle %0d sampled at cycle %0d", e.name, e.cyc, cyc);
      end else if (reset_o !== e.rst || reset_cause !== e.cause) begin
        errors++;
        $display("FAIL %0s cycle %0d: reset_o=%b reset_cause=%b, required reset_o=%b reset_cause=%b",
                 e.name, cyc, reset_o, reset_cause, e.rst, e.cause);
      end
    end
  end

  initial begin
    int now;
    int n2;
    logic [1:0] exp_cause;

    // Power-on: external reset low for 5 cycles, then 2 sync + 4 hold
    #1 reset = 1'b0;
    expect_range(1, 5, 1'b1, CAUSE_POR, "por_asserted");
    tick(5);
    now = cyc;
    reset = 1'b1;
    expect_range(now + 1, now + 5, 1'b1, CAUSE_POR, "por_hold");
    expect_at(now + 6, 1'b0, CAUSE_POR, "por_release");
    tick(6);

    // Short button glitch must be filtered out
    now = cyc;
    expect_range(now + 1, now + 16, 1'b0, CAUSE_POR, "btn_glitch");
    btn = 1'b0;
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    tick(4);
    btn = 1'b1;
    tick(11);

    // Held button: reset after 2+8+1, release after 2+8 then 4 hold
    now = cyc;
    btn = 1'b0;
    expect_range(now + 1, now + 10, 1'b0, CAUSE_POR, "btn_press_pre");
    expect_at(now + 11, 1'b1, CAUSE_BTN, "btn_press_assert");
    expect_range(now + 12, now + 34, 1'b1, CAUSE_BTN, "btn_wait_hold");
    expect_at(now + 35, 1'b0, CAUSE_BTN, "btn_release");
    tick(20);
    btn = 1'b1;
    tick(15);

`ifdef RESET_MANAGER_WATCHDOG_EN
    now = cyc;
    expect_range(now + 1, now + 31, 1'b0, CAUSE_BTN, "wdt_run");
    expect_at(now + 32, 1'b1, CAUSE_WDT, "wdt_fire");
    expect_range(now + 33, now + 35, 1'b1, CAUSE_WDT, "wdt_hold");
    expect_at(now + 36, 1'b0, CAUSE_WDT, "wdt_release");
    tick(36);
    exp_cause = CAUSE_WDT;
`else
    exp_cause = CAUSE_BTN;
`endif

    // 100 cycles with a kick every 20: never resets
    now = cyc;
    expect_range(now + 1, now + 100, 1'b0, exp_cause, "wdt_kicked");
    for (int i = 0; i < 5; i++) begin
      tick(19);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
    end

    // External reset pulsed during BTN_WAIT restarts the full hold
    now = cyc;
    btn = 1'b0;
    expect_range(now + 1, now + 10, 1'b0, exp_cause, "bw_pre");
    expect_range(now + 11, now + 13, 1'b1, CAUSE_BTN, "bw_enter");
    tick(14);
    reset = 1'b0;
    btn = 1'b1;
    expect_at(now + 14, 1'b1, CAUSE_POR, "bw_ext_reset");
    tick(1);
    reset = 1'b1;
    n2 = cyc;
    expect_range(n2 + 1, n2 + 5, 1'b1, CAUSE_POR, "bw_rehold");
    expect_at(n2 + 6, 1'b0, CAUSE_POR, "bw_rerelease");
    tick(6);

    // Debounced press lands on the same edge a watchdog timeout would
    now = cyc;
    expect_range(now + 1, now + 31, 1'b0, CAUSE_POR, "sim_pre");
    expect_at(now + 32, 1'b1, CAUSE_BTN, "sim_cause");
    expect_range(now + 33, now + 40, 1'b1, CAUSE_BTN, "sim_btn_wait");
    tick(21);
    btn = 1'b0;
    tick(19);
    btn = 1'b1;

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations never sampled, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
